sr_range_counter: RTL and testbench
===================================

SR_RANGE_COUNTER -- requirements
Module: sr_range_counter

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, default 10: width of the SR_TRIG pulse, in clock cycles.
REQ-002 SHALL have parameter CYC_PER_CM, default 58: clock cycles per centimetre of echo window.
REQ-003 SHALL have parameter MAX_CM, default 400: saturation value of the distance.
REQ-004 SHALL have parameter WAIT_TIMEOUT, default 30000: maximum number of cycles to wait for the echo window to open.
REQ-005 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port START, input, 1 bit: request one measurement; sampled only in IDLE.
REQ-008 SHALL have port MEAS_EN, input, 1 bit: echo measurement window, asynchronous to CLK, high while the window is open (produced by end_of_measure).
REQ-009 SHALL have port SR_TRIG, output, 1 bit: trigger pulse to the sensor.
REQ-010 SHALL have port DIST_CM, output, 9 bits: last measured distance in cm.
REQ-011 SHALL have port DIST_VALID, output, 1 bit: single-cycle strobe marking a new DIST_CM.
REQ-012 SHALL have port OUT_OF_RANGE, output, 1 bit: last result saturated at MAX_CM.
REQ-013 SHALL have port TIMEOUT, output, 1 bit: last attempt saw no echo window.
REQ-014 SHALL have port BUSY, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 SHALL pass MEAS_EN through a 2-flop synchronizer; all edge detection uses the synchronized value (2-cycle input latency).
REQ-016 SHALL implement the states IDLE, TRIG, WAIT, COUNT and DONE, with the transitions in REQ-017 to REQ-022.
REQ-017 IDLE: START=1 -> TRIG; the same edge clears TIMEOUT; START is ignored in every other state.
REQ-018 TRIG: SR_TRIG=1 for exactly TRIG_CYCLES cycles, starting the cycle after START is sampled, then -> WAIT; SR_TRIG=0 in all other states.
REQ-019 WAIT: a rising edge of the synchronized MEAS_EN -> COUNT, clearing the prescaler and the cm counter.
REQ-020 WAIT: after WAIT_TIMEOUT cycles with no rising edge -> IDLE with TIMEOUT=1 (sticky until the next START); DIST_CM is unchanged and DIST_VALID stays low.
REQ-021 COUNT: the prescaler counts 0..CYC_PER_CM-1; on each wrap the cm counter increments; result = floor(N/CYC_PER_CM), where N = number of synchronized-high cycles.
REQ-022 COUNT: the cm counter saturates at MAX_CM; once saturated, further wraps are ignored and an overflow flag is set.
REQ-023 COUNT: a falling edge of the synchronized MEAS_EN -> DONE.
REQ-024 DONE (one cycle): DIST_CM <= cm counter; OUT_OF_RANGE <= overflow flag; DIST_VALID=1 for this cycle only; then -> IDLE.
REQ-025 DIST_CM and OUT_OF_RANGE SHALL hold their values between DONE states.
REQ-026 The window is already high on entry to WAIT (no rising edge seen): SHALL NOT count; the rising-edge requirement stands, so this case ends in a timeout.
REQ-027 START=1 held continuously SHALL start a new measurement on the cycle after DONE returns to IDLE (back-to-back operation).
REQ-028 All counters SHALL be sized from the parameters with no wrap-around; the WAIT timer never overflows before WAIT_TIMEOUT.

Reset
REQ-029 RESET=1 SHALL force, asynchronously: state=IDLE; SR_TRIG=0, DIST_CM=0, DIST_VALID=0, OUT_OF_RANGE=0, TIMEOUT=0, BUSY=0; all counters and synchronizer flops=0.
REQ-030 RESET asserted mid-measurement (in any state) SHALL abort it with no DIST_VALID; after release, the block waits in IDLE for START.

Verification
REQ-031 START pulse, then MEAS_EN high for 580 cycles -> SR_TRIG high exactly 10 cycles; DIST_CM=10, DIST_VALID one cycle, OUT_OF_RANGE=0.
REQ-032 MEAS_EN high for 637 cycles -> DIST_CM=10 (floor); 638 cycles -> DIST_CM=11.
REQ-033 MEAS_EN high for 30000 cycles -> DIST_CM=400, OUT_OF_RANGE=1.
REQ-034 START with MEAS_EN never rising -> TIMEOUT=1 after 30000 WAIT cycles; BUSY falls; DIST_CM keeps its previous value.
REQ-035 RESET pulse during COUNT -> all outputs 0 immediately; no DIST_VALID; a following START/580-cycle window -> DIST_CM=10.
REQ-036 START pulsed while BUSY -> ignored: exactly one DIST_VALID per accepted START.

Source files
------------

// File: rtl/sr_range_counter.sv
// sr_range_counter: ultrasonic ranger trigger and echo-width measurement.
// Converts the synchronized echo window width into whole centimetres.
module sr_range_counter #(
    parameter int TRIG_CYCLES  = 10,
    parameter int CYC_PER_CM   = 58,
    parameter int MAX_CM       = 400,
    parameter int WAIT_TIMEOUT = 30000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       MEAS_EN,
    output logic       SR_TRIG,
    output logic [8:0] DIST_CM,
    output logic       DIST_VALID,
    output logic       OUT_OF_RANGE,
    output logic       TIMEOUT,
    output logic       BUSY
);

    localparam int TW = $clog2(TRIG_CYCLES + 1);
    localparam int PW = $clog2(CYC_PER_CM + 1);
    localparam int CW = $clog2(MAX_CM + 1);
    localparam int WW = $clog2(WAIT_TIMEOUT + 1);

    localparam logic [TW-1:0] TRIG_LAST  = TW'(TRIG_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CYC_PER_CM - 1);
    localparam logic [CW-1:0] CM_MAX     = CW'(MAX_CM);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_COUNT,
        S_DONE
    } state_t;

    state_t          state;
    logic            meas_s1;
    logic            meas_s2;
    logic            meas_d;
    logic [TW-1:0]   trig_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [PW-1:0]   presc;
    logic [CW-1:0]   cm;
    logic            ovf;

    logic            rise;
    logic            fall;
    logic            wrap;
    logic [PW-1:0]   presc_nx;
    logic [CW-1:0]   cm_nx;
    logic            ovf_nx;

    assign rise = meas_s2 & ~meas_d;
    assign fall = ~meas_s2 & meas_d;
    assign BUSY = (state != S_IDLE);

    always_comb begin
        wrap     = (presc == PRESC_LAST);
        presc_nx = wrap ? '0 : presc + PW'(1);
        cm_nx    = cm;
        ovf_nx   = ovf;
        if (wrap) begin
            if (cm == CM_MAX) begin
                ovf_nx = 1'b1;
            end else begin
                cm_nx = cm + CW'(1);
            end
        end
    end

    // The rising-edge cycle is spent in WAIT, so the falling-edge cycle
    // still ticks the prescaler; ticks then equal synchronized-high cycles.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= S_IDLE;
            meas_s1      <= 1'b0;
            meas_s2      <= 1'b0;
            meas_d       <= 1'b0;
            trig_cnt     <= '0;
            wait_cnt     <= '0;
            presc        <= '0;
            cm           <= '0;
            ovf          <= 1'b0;
            SR_TRIG      <= 1'b0;
            DIST_CM      <= '0;
            DIST_VALID   <= 1'b0;
            OUT_OF_RANGE <= 1'b0;
            TIMEOUT      <= 1'b0;
        end else begin
            meas_s1 <= MEAS_EN;
            meas_s2 <= meas_s1;
            meas_d  <= meas_s2;
            unique case (state)
                S_IDLE: begin
                    if (START) begin
                        state    <= S_TRIG;
                        SR_TRIG  <= 1'b1;
                        trig_cnt <= '0;
                        TIMEOUT  <= 1'b0;
                    end
                end
                S_TRIG: begin
                    if (trig_cnt == TRIG_LAST) begin
                        state    <= S_WAIT;
                        SR_TRIG  <= 1'b0;
                        wait_cnt <= '0;
                    end else begin
                        trig_cnt <= trig_cnt + TW'(1);
                    end
                end
                S_WAIT: begin
                    if (rise) begin
                        state <= S_COUNT;
                        presc <= '0;
                        cm    <= '0;
                        ovf   <= 1'b0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= S_IDLE;
                        TIMEOUT <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_COUNT: begin
                    presc <= presc_nx;
                    cm    <= cm_nx;
                    ovf   <= ovf_nx;
                    if (fall) begin
                        state        <= S_DONE;
                        DIST_CM      <= 9'(cm_nx);
                        OUT_OF_RANGE <= ovf_nx;
                        DIST_VALID   <= 1'b1;
                    end
                end
                S_DONE: begin
                    DIST_VALID <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_range_counter.sv
// tb_sr_range_counter: directed checks of trigger width, distance
// conversion, saturation, timeout, reset abort and START handling.
module tb_sr_range_counter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic       MEAS_EN;
    logic       SR_TRIG;
    logic [8:0] DIST_CM;
    logic       DIST_VALID;
    logic       OUT_OF_RANGE;
    logic       TIMEOUT;
    logic       BUSY;

    int n_checks = 0;
    int n_fail   = 0;
    int trig_total  = 0;
    int valid_total = 0;
    logic [8:0] valid_cm = '0;

    always #5 CLK = ~CLK;

    sr_range_counter dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .START        (START),
        .MEAS_EN      (MEAS_EN),
        .SR_TRIG      (SR_TRIG),
        .DIST_CM      (DIST_CM),
        .DIST_VALID   (DIST_VALID),
        .OUT_OF_RANGE (OUT_OF_RANGE),
        .TIMEOUT      (TIMEOUT),
        .BUSY         (BUSY)
    );

    always @(negedge CLK) begin
        if (SR_TRIG === 1'b1) trig_total++;
        if (DIST_VALID === 1'b1) begin
            valid_total++;
            valid_cm = DIST_CM;
        end
    end

    task automatic pulse_start;
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
    endtask

    task automatic window(input int n);
        MEAS_EN = 1'b1;
        repeat (n) @(negedge CLK);
        MEAS_EN = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (BUSY === 1'b1 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: BUSY=%b required 0", nm, BUSY);
        end
    endtask

    task automatic run_meas(input int n, input int exp_cm,
                            input logic exp_oor, input string nm);
        int t0 = trig_total;
        int v0 = valid_total;
        pulse_start();
        n_checks++;
        if (BUSY !== 1'b1 || SR_TRIG !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_start: BUSY=%b SR_TRIG=%b required 1 1",
                     nm, BUSY, SR_TRIG);
        end
        repeat (12) @(negedge CLK);
        window(n);
        wait_idle(nm);
        repeat (2) @(negedge CLK);
        n_checks++;
        if (trig_total - t0 !== 10) begin
            n_fail++;
            $display("FAIL %s_trig: %0d cycles required 10", nm, trig_total - t0);
        end
        n_checks++;
        if (valid_total - v0 !== 1) begin
            n_fail++;
            $display("FAIL %s_valid: %0d strobes required 1", nm, valid_total - v0);
        end
        n_checks++;
        if (valid_cm !== 9'(exp_cm)) begin
            n_fail++;
            $display("FAIL %s_strobe_cm: %0d required %0d", nm, valid_cm, exp_cm);
        end
        n_checks++;
        if (DIST_CM !== 9'(exp_cm)) begin
            n_fail++;
            $display("FAIL %s_cm: %0d required %0d", nm, DIST_CM, exp_cm);
        end
        n_checks++;
        if (OUT_OF_RANGE !== exp_oor || TIMEOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_flags: OOR=%b TIMEOUT=%b required %b 0",
                     nm, OUT_OF_RANGE, TIMEOUT, exp_oor);
        end
    endtask

    task automatic test_reset;
        RESET   = 1'b1;
        START   = 1'b0;
        MEAS_EN = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({SR_TRIG, DIST_CM, DIST_VALID, OUT_OF_RANGE, TIMEOUT, BUSY} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: trig=%b cm=%0d v=%b oor=%b to=%b busy=%b required all 0",
                     SR_TRIG, DIST_CM, DIST_VALID, OUT_OF_RANGE, TIMEOUT, BUSY);
        end
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: BUSY=%b required 0", BUSY);
        end
    endtask

    task automatic test_basic;
        run_meas(580, 10, 1'b0, "basic580");
    endtask

    task automatic test_floor;
        run_meas(637, 10, 1'b0, "floor637");
        run_meas(638, 11, 1'b0, "floor638");
    endtask

    task automatic test_saturate;
        run_meas(30000, 400, 1'b1, "sat30000");
        run_meas(580, 10, 1'b0, "after_sat");
    endtask

    task automatic test_timeout;
        int v0 = valid_total;
        pulse_start();
        repeat (30009) @(negedge CLK);
        n_checks++;
        if (BUSY !== 1'b1 || TIMEOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: BUSY=%b TIMEOUT=%b required 1 0", BUSY, TIMEOUT);
        end
        @(negedge CLK);
        n_checks++;
        if (BUSY !== 1'b0 || TIMEOUT !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_edge: BUSY=%b TIMEOUT=%b required 0 1", BUSY, TIMEOUT);
        end
        repeat (5) @(negedge CLK);
        n_checks++;
        if (DIST_CM !== 9'd10 || OUT_OF_RANGE !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_hold: cm=%0d oor=%b required 10 0", DIST_CM, OUT_OF_RANGE);
        end
        n_checks++;
        if (valid_total != v0 || TIMEOUT !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: strobes=%0d TIMEOUT=%b required 0 1",
                     valid_total - v0, TIMEOUT);
        end
    endtask

    task automatic test_reset_mid;
        int v0 = valid_total;
        pulse_start();
        n_checks++;
        if (TIMEOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL start_clears_timeout: TIMEOUT=%b required 0", TIMEOUT);
        end
        repeat (12) @(negedge CLK);
        MEAS_EN = 1'b1;
        repeat (200) @(negedge CLK);
        n_checks++;
        if (BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_busy: BUSY=%b required 1", BUSY);
        end
        RESET = 1'b1;
        #1;
        n_checks++;
        if ({SR_TRIG, DIST_CM, DIST_VALID, OUT_OF_RANGE, TIMEOUT, BUSY} !== 14'd0) begin
            n_fail++;
            $display("FAIL midreset_async: cm=%0d busy=%b v=%b required 0 0 0",
                     DIST_CM, BUSY, DIST_VALID);
        end
        @(negedge CLK) RESET = 1'b0;
        repeat (400) @(negedge CLK);
        MEAS_EN = 1'b0;
        repeat (20) @(negedge CLK);
        n_checks++;
        if (BUSY !== 1'b0 || valid_total != v0) begin
            n_fail++;
            $display("FAIL midreset_abort: BUSY=%b strobes=%0d required 0 0",
                     BUSY, valid_total - v0);
        end
        run_meas(580, 10, 1'b0, "after_reset");
    endtask

    task automatic test_busy_start;
        int t0 = trig_total;
        int v0 = valid_total;
        pulse_start();
        repeat (3) @(negedge CLK);
        pulse_start();
        repeat (7) @(negedge CLK);
        MEAS_EN = 1'b1;
        repeat (100) @(negedge CLK);
        pulse_start();
        repeat (478) @(negedge CLK);
        MEAS_EN = 1'b0;
        wait_idle("busy_start");
        repeat (20) @(negedge CLK);
        n_checks++;
        if (BUSY !== 1'b0 || valid_total - v0 !== 1 || trig_total - t0 !== 10) begin
            n_fail++;
            $display("FAIL busy_start_ignored: BUSY=%b strobes=%0d trig=%0d required 0 1 10",
                     BUSY, valid_total - v0, trig_total - t0);
        end
        n_checks++;
        if (DIST_CM !== 9'd10) begin
            n_fail++;
            $display("FAIL busy_start_cm: %0d required 10", DIST_CM);
        end
    endtask

    task automatic test_back_to_back;
        int t0 = trig_total;
        int v0 = valid_total;
        int k = 0;
        @(negedge CLK) START = 1'b1;
        repeat (12) @(negedge CLK);
        window(580);
        while (DIST_VALID !== 1'b1 && k < 50) begin
            @(negedge CLK);
            k++;
        end
        n_checks++;
        if (DIST_VALID !== 1'b1 || DIST_CM !== 9'd10) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b cm=%0d required 1 10", DIST_VALID, DIST_CM);
        end
        @(negedge CLK);
        n_checks++;
        if (BUSY !== 1'b0 || DIST_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: BUSY=%b valid=%b required 0 0", BUSY, DIST_VALID);
        end
        @(negedge CLK);
        n_checks++;
        if (BUSY !== 1'b1 || SR_TRIG !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: BUSY=%b SR_TRIG=%b required 1 1", BUSY, SR_TRIG);
        end
        START = 1'b0;
        repeat (12) @(negedge CLK);
        window(638);
        wait_idle("b2b");
        repeat (2) @(negedge CLK);
        n_checks++;
        if (DIST_CM !== 9'd11 || valid_total - v0 !== 2 || trig_total - t0 !== 20) begin
            n_fail++;
            $display("FAIL b2b_second: cm=%0d strobes=%0d trig=%0d required 11 2 20",
                     DIST_CM, valid_total - v0, trig_total - t0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_floor();
        test_saturate();
        test_timeout();
        test_reset_mid();
        test_busy_start();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
